// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART transmitter through its en/busy/ack handshake.
// Define UART_TX_FIFO_IRQ_EN to build the low-water interrupt; otherwise irq is tied low.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_WIDTH = 4,
    parameter int unsigned LOW_WATER   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 flush,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_WIDTH:0] count,
    output logic                 overflow,
    output logic                 irq,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_ack
);

    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam int unsigned CW    = DEPTH_WIDTH + 1;

    if (LOW_WATER > DEPTH) begin : g_bad_low_water
        $error("LOW_WATER exceeds FIFO depth");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic                   drop;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          count_next;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign tx_en   = (state == S_REQ);
    assign tx_data = empty ? 8'h00 : mem[rd_ptr];

    // Flush outranks both a write and a completing transfer.
    assign push = wr_en && !full && !flush;
    assign pop  = (state == S_ACK) && tx_ack && !drop && !flush && !empty;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (!empty && !tx_busy && !flush) state_next = S_REQ;
            S_REQ:  if (tx_busy) state_next = S_ACK;
            S_ACK:  if (tx_ack) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The in-flight byte was flushed away if drop is set when its ack arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
                if (pop)  rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
            end
            count    <= count_next;
            overflow <= wr_en && full && !flush;
            if ((state == S_ACK) && tx_ack) begin
                drop <= 1'b0;
            end else if (flush && (state != S_IDLE)) begin
                drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

`ifdef UART_TX_FIFO_IRQ_EN
    localparam logic [CW-1:0] LOW_WATER_C = CW'(LOW_WATER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (count_next <= LOW_WATER_C);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter on the tx side.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_IRQ_EN
    localparam bit IRQ_EXP = 1'b1;
`else
    localparam bit IRQ_EXP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       irq;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_ack;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    bit         stall = 1'b0;
    int         acks_allowed = 0;
    int         ack_delay = 100;
    int         ack_timer = 0;
    int         ack_cnt = 0;
    int         load_cnt = 0;
    bit         pend = 1'b0;
    logic [7:0] cap;

    uart_tx_fifo #(.DEPTH_WIDTH(4), .LOW_WATER(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .irq(irq),
        .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .tx_ack(tx_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transmitter: sees en, loads on the next edge, holds busy, then acks and idles together.
    initial begin
        tx_busy = 1'b0;
        tx_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_busy = 1'b0;
                tx_ack  = 1'b0;
                pend    = 1'b0;
            end else if (tx_ack) begin
                tx_ack  = 1'b0;
                tx_busy = 1'b0;
            end else if (pend) begin
                pend      = 1'b0;
                tx_busy   = 1'b1;
                ack_timer = ack_delay;
                load_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_unexpected: got %h expected no transfer", cap);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (cap !== e) begin
                        errors++;
                        $display("FAIL load_data: got %h expected %h", cap, e);
                    end
                end
            end else if (tx_busy) begin
                if (stall) begin
                    if (acks_allowed > 0) begin
                        acks_allowed--;
                        tx_ack = 1'b1;
                        ack_cnt++;
                    end
                end else if (ack_timer <= 1) begin
                    tx_ack = 1'b1;
                    ack_cnt++;
                end else begin
                    ack_timer--;
                end
            end else if (tx_en) begin
                pend = 1'b1;
                cap  = tx_data;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (irq !== IRQ_EXP) begin errors++; $display("FAIL post_reset_irq: got %b expected %b", irq, IRQ_EXP); end
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL post_reset_tx_en: got %b expected 0", tx_en); end
    endtask

    task automatic test_single;
        int cyc;
        stall = 1'b0; ack_delay = 100;
        exp_q.push_back(8'hA5);
        push_byte(8'hA5);
        @(negedge clk);
        checks++; if (count !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL single_count: got count %0d empty %b expected 1 0", count, empty); end
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_en_early: got %b expected 0", tx_en); end
        @(negedge clk);
        checks++; if (tx_en !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_en_rise: got en %b data %h expected 1 a5", tx_en, tx_data); end
        @(negedge clk);
        checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL single_en_second: got %b expected 1", tx_en); end
        @(negedge clk);
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_en_fall: got %b expected 0", tx_en); end
        cyc = 0;
        while (count == 5'd1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_pop: got count %0d empty %b expected 0 1", count, empty); end
        checks++; if (cyc < 90) begin errors++; $display("FAIL single_pop_timing: got pop after %0d cycles expected at least 90", cyc); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fill_overflow;
        stall = 1'b1; acks_allowed = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_data = 8'(i);
            exp_q.push_back(8'(i));
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL fill_full: got full %b count %0d expected 1 16", full, count); end
        checks++; if (overflow !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL fill_flags: got ovf %b irq %b expected 0 0", overflow, irq); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = 8'h99;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_pulse: got ovf %b count %0d expected 1 16", overflow, count); end
        @(negedge clk);
        checks++; if (overflow !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL ovf_one_cycle: got ovf %b count %0d expected 0 16", overflow, count); end
    endtask

    task automatic test_overflow_with_pop;
        int cyc;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = 8'hEE; acks_allowed = 1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b1 || count !== 5'd15 || full !== 1'b0) begin errors++; $display("FAIL ovf_pop: got ovf %b count %0d full %b expected 1 15 0", overflow, count, full); end
        ack_delay = 3; stall = 1'b0;
        cyc = 0;
        while (count != 5'd0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
        repeat (6) @(negedge clk);
        checks++; if (exp_q.size() != 0 || empty !== 1'b1) begin errors++; $display("FAIL drain_all: got %0d pending empty %b expected 0 1", exp_q.size(), empty); end
    endtask

    task automatic test_flush;
        int cyc;
        int a;
        int l;
        stall = 1'b1; acks_allowed = 0; ack_delay = 3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_data = 8'h10 + 8'(i);
            exp_q.push_back(8'h10 + 8'(i));
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_clear: got count %0d empty %b expected 0 1", count, empty); end
        exp_q.push_back(8'h3C);
        push_byte(8'h3C);
        @(negedge clk);
        checks++; if (count !== 5'd1 || tx_data !== 8'h3C) begin errors++; $display("FAIL flush_push: got count %0d data %h expected 1 3c", count, tx_data); end
        #1;
        a = ack_cnt; l = load_cnt;
        acks_allowed = 1;
        cyc = 0;
        while (ack_cnt == a && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        checks++; if (ack_cnt == a) begin errors++; $display("FAIL flush_ack_seen: got no ack expected one within 20 cycles"); end
        @(negedge clk);
        checks++; if (count !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL flush_ack_no_pop: got count %0d empty %b expected 1 0", count, empty); end
        cyc = 0;
        while (load_cnt == l && cyc < 40) begin
            @(negedge clk); #1;
            cyc++;
        end
        checks++; if (load_cnt == l) begin errors++; $display("FAIL flush_next_load: got no transfer expected 3c"); end
        stall = 1'b0;
        cyc = 0;
        while (count != 5'd0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_final_pop: got %0d expected 0", count); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit stale;
        stall = 1'b0; ack_delay = 50;
        exp_q.push_back(8'h77);
        push_byte(8'h77);
        cyc = 0;
        while (tx_en !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL rstmid_en_seen: got %b expected 1", tx_en); end
        rst = 1'b1;
        #1;
        checks++; if (tx_en !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL rstmid_drop: got en %b count %0d expected 0 0", tx_en, count); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_en !== 1'b0 || count !== 5'd0) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rstmid_no_stale: got activity after reset expected none"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_overflow_with_pop();
        test_flush();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
